facto_master: RTL and testbench

FACTO_MASTER -- requirements
Module: facto_master

---
 rtl/facto_master.sv | 164 ++++++++++++++++
 tb/tb_facto_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/facto_master.sv
// facto_master: sequences a register-mapped factorial core over a simple
// single-cycle bus; takes an operand on a valid/ready command port and
// returns the 128-bit result (or a timeout error) on a valid/ready result port.
module facto_master #(
  parameter int unsigned USE_INTR = 1,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TIMEOUT  = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_operand,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_err,
  output logic         busy,
  output logic         m_sel,
  output logic         m_wr,
  output logic [15:0]  m_addr,
  output logic [63:0]  m_dout,
  input  logic [63:0]  m_din,
  input  logic         m_intr
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned GW = 8;
  localparam int unsigned TW = 32;

  localparam logic [AW-1:0] A_START  = 16'h0000;
  localparam logic [AW-1:0] A_CLEAR  = 16'h0008;
  localparam logic [AW-1:0] A_DONE   = 16'h0010;
  localparam logic [AW-1:0] A_IEN    = 16'h0018;
  localparam logic [AW-1:0] A_OPND   = 16'h0020;
  localparam logic [AW-1:0] A_RES_H  = 16'h0028;
  localparam logic [AW-1:0] A_RES_L  = 16'h0030;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR1, S_CLR0, S_WOPND, S_WIEN, S_WSTART, S_WAIT,
    S_POLL, S_RDH, S_RDL, S_FCLR1, S_FCLR0, S_OUT
  } state_t;

  state_t          state, state_next;
  logic            sel_n, wr_n;
  logic [AW-1:0]   addr_n;
  logic [DW-1:0]   dout_n;
  logic [DW-1:0]   operand;
  logic [GW-1:0]   gap_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            xfer;
  logic            waiting;

  assign xfer    = cmd_valid && (state == S_IDLE);
  assign waiting = (state == S_WAIT) || (state == S_POLL);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT));

  // Next-state decode, then the bus access belonging to the next state.
  always_comb begin
    state_next = state;
    sel_n      = 1'b0;
    wr_n       = 1'b0;
    addr_n     = '0;
    dout_n     = '0;
    case (state)
      S_IDLE:   if (xfer) state_next = S_CLR1;
      S_CLR1:   state_next = S_CLR0;
      S_CLR0:   state_next = S_WOPND;
      S_WOPND:  state_next = S_WIEN;
      S_WIEN:   state_next = S_WSTART;
      S_WSTART: state_next = S_WAIT;
      S_WAIT: begin
        if (tmo_hit)                            state_next = S_FCLR1;
        else if (USE_INTR != 0) begin
          if (m_intr)                           state_next = S_RDH;
        end else if (gap_cnt == '0)             state_next = S_POLL;
      end
      S_POLL: begin
        if (tmo_hit)                            state_next = S_FCLR1;
        else if (m_din[0])                      state_next = S_RDH;
        else                                    state_next = S_WAIT;
      end
      S_RDH:    state_next = S_RDL;
      S_RDL:    state_next = S_FCLR1;
      S_FCLR1:  state_next = S_FCLR0;
      S_FCLR0:  state_next = S_OUT;
      S_OUT:    if (res_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    case (state_next)
      S_CLR1, S_FCLR1: begin sel_n = 1'b1; wr_n = 1'b1; addr_n = A_CLEAR; dout_n = DW'(1); end
      S_CLR0, S_FCLR0: begin sel_n = 1'b1; wr_n = 1'b1; addr_n = A_CLEAR; end
      S_WOPND:  begin sel_n = 1'b1; wr_n = 1'b1; addr_n = A_OPND;  dout_n = operand; end
      S_WIEN:   begin sel_n = 1'b1; wr_n = 1'b1; addr_n = A_IEN;   dout_n = DW'(USE_INTR != 0); end
      S_WSTART: begin sel_n = 1'b1; wr_n = 1'b1; addr_n = A_START; dout_n = DW'(1); end
      S_POLL:   begin sel_n = 1'b1; addr_n = A_DONE;  end
      S_RDH:    begin sel_n = 1'b1; addr_n = A_RES_H; end
      S_RDL:    begin sel_n = 1'b1; addr_n = A_RES_L; end
      default:  ;
    endcase
  end

  // State register plus registered bus and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      m_sel     <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_dout    <= '0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == S_IDLE);
      busy      <= (state_next != S_IDLE);
      res_valid <= (state_next == S_OUT);
      m_sel     <= sel_n;
      m_wr      <= wr_n;
      m_addr    <= addr_n;
      m_dout    <= dout_n;
    end
  end

  // Operand capture, result latching and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand  <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      if (xfer) begin
        operand <= cmd_operand;
        res_err <= 1'b0;
      end
      if (waiting && tmo_hit) begin
        res_err  <= 1'b1;
        res_data <= '0;
      end else if (state == S_RDH) begin
        res_data[127:64] <= m_din;
      end else if (state == S_RDL) begin
        res_data[63:0] <= m_din;
      end
    end
  end

  // Poll-gap counter reloads outside WAIT; timeout counter runs across WAIT/POLL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == S_WAIT) gap_cnt <= gap_cnt - GW'(1);
      else                 gap_cnt <= GW'(POLL_GAP - 1);
      if (waiting)         tmo_cnt <= tmo_cnt + TW'(1);
      else                 tmo_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_facto_master.sv
// Bench for facto_master: two instances (interrupt mode with timeout, poll mode)
// each attached to a behavioural factorial core model.
module tb_facto_master;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] dout;
    int          cyc;
  } bus_t;

  typedef struct {
    int           inst;
    logic [63:0]  op;
    logic [127:0] exp_data;
    int           hold;
  } vec_t;

  logic clk = 1'b0;
  logic         rst [2];
  logic         cmd_valid [2];
  logic         cmd_ready [2];
  logic [63:0]  cmd_operand [2];
  logic         res_valid [2];
  logic         res_ready [2];
  logic [127:0] res_data [2];
  logic         res_err [2];
  logic         busy [2];
  logic         m_sel [2];
  logic         m_wr [2];
  logic [15:0]  m_addr [2];
  logic [63:0]  m_dout [2];
  logic [63:0]  m_din [2];
  logic         m_intr [2];

  // core model state
  logic         c_done [2] = '{1'b0, 1'b0};
  logic         c_ien  [2] = '{1'b0, 1'b0};
  logic         c_run  [2] = '{1'b0, 1'b0};
  logic [63:0]  c_opnd [2] = '{64'd0, 64'd0};
  logic [127:0] c_res  [2] = '{128'd0, 128'd0};
  int           c_cnt  [2] = '{0, 0};
  int           c_lat  [2];
  logic         c_never [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int intr_w = -1;
  int last_tc = 0;
  int last_rv = 0;
  bus_t bq0[$];
  bus_t bq1[$];

  always #5 clk = ~clk;

  facto_master #(.USE_INTR(1), .POLL_GAP(4), .TIMEOUT(50)) u_intr (
    .clk(clk), .reset(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_operand(cmd_operand[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_data(res_data[0]), .res_err(res_err[0]), .busy(busy[0]), .m_sel(m_sel[0]),
    .m_wr(m_wr[0]), .m_addr(m_addr[0]), .m_dout(m_dout[0]), .m_din(m_din[0]),
    .m_intr(m_intr[0]));

  facto_master #(.USE_INTR(0), .POLL_GAP(4), .TIMEOUT(0)) u_poll (
    .clk(clk), .reset(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_operand(cmd_operand[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_data(res_data[1]), .res_err(res_err[1]), .busy(busy[1]), .m_sel(m_sel[1]),
    .m_wr(m_wr[1]), .m_addr(m_addr[1]), .m_dout(m_dout[1]), .m_din(m_din[1]),
    .m_intr(m_intr[1]));

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r;
    r = 128'd1;
    for (logic [63:0] i = 64'd2; i <= n; i++) r = r * {64'd0, i};
    return r;
  endfunction

  // Factorial core: register writes, and a run that finishes c_lat cycles after start.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (m_sel[c] && m_wr[c]) begin
        case (m_addr[c])
          16'h0000: if (m_dout[c][0]) begin c_run[c] <= 1'b1; c_cnt[c] <= c_lat[c]; end
          16'h0008: if (m_dout[c][0]) begin c_run[c] <= 1'b0; c_done[c] <= 1'b0; c_res[c] <= '0; end
          16'h0018: c_ien[c] <= m_dout[c][0];
          16'h0020: c_opnd[c] <= m_dout[c];
          default: ;
        endcase
      end else if (c_run[c] && !c_never[c]) begin
        if (c_cnt[c] == 0) begin
          c_done[c] <= 1'b1;
          c_run[c]  <= 1'b0;
          c_res[c]  <= fact(c_opnd[c]);
        end else begin
          c_cnt[c] <= c_cnt[c] - 1;
        end
      end
    end
  end

  // Core read mux and interrupt.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      m_intr[c] = c_ien[c] & c_done[c];
      m_din[c]  = '0;
      if (m_sel[c] && !m_wr[c]) begin
        case (m_addr[c])
          16'h0010: m_din[c] = {63'd0, c_done[c]};
          16'h0028: m_din[c] = c_res[c][127:64];
          16'h0030: m_din[c] = c_res[c][63:0];
          default:  m_din[c] = '0;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle, sample just after the edge, log bus accesses.
  task automatic tick();
    bus_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < 2; c++) begin
      if (m_sel[c] === 1'b1) begin
        e.wr = m_wr[c]; e.addr = m_addr[c]; e.dout = m_dout[c]; e.cyc = cyc;
        if (c == 0) bq0.push_back(e); else bq1.push_back(e);
      end else begin
        chk("bus_idle_zero", 128'({m_sel[c], m_wr[c], m_addr[c], m_dout[c]}), 128'd0);
      end
    end
    if (m_intr[0] && intr_w < 0 && cyc > last_tc + 5) intr_w = cyc;
  endtask

  task automatic run_cmd(input int c, input logic [63:0] op, input int hold,
                         output logic [127:0] data, output logic err);
    int n;
    if (c == 0) bq0.delete(); else bq1.delete();
    intr_w = -1;
    cmd_operand[c] = op;
    cmd_valid[c]   = 1'b1;
    n = 0;
    while (cmd_ready[c] !== 1'b1 && n < 100) begin tick(); n++; end
    chk("cmd_ready_wait", 128'(n < 100), 128'd1);
    last_tc = cyc;
    tick();
    cmd_valid[c]   = 1'b0;
    cmd_operand[c] = '0;
    chk("busy_after_xfer", 128'(busy[c]), 128'd1);
    chk("err_clr_on_xfer", 128'(res_err[c]), 128'd0);
    n = 0;
    while (res_valid[c] !== 1'b1 && n < 2000) begin tick(); n++; end
    chk("res_valid_wait", 128'(n < 2000), 128'd1);
    last_rv = cyc;
    data = res_data[c];
    err  = res_err[c];
    for (int i = 0; i < hold; i++) begin
      cmd_valid[c]   = ~i[0];
      cmd_operand[c] = 64'hDEAD_BEEF;
      tick();
      chk("hold_data", res_data[c], data);
      chk("hold_err", 128'(res_err[c]), 128'(err));
      chk("hold_cmd_ready", 128'(cmd_ready[c]), 128'd0);
      chk("hold_res_valid", 128'(res_valid[c]), 128'd1);
    end
    cmd_valid[c]   = 1'b0;
    cmd_operand[c] = '0;
    res_ready[c]   = 1'b1;
    tick();
    res_ready[c]   = 1'b0;
    chk("ready_after_hs", 128'(cmd_ready[c]), 128'd1);
    chk("valid_after_hs", 128'(res_valid[c]), 128'd0);
    chk("data_kept_after_hs", res_data[c], data);
  endtask

  // Compare the logged bus traffic of the last command against the expected sequence.
  task automatic check_seq(input int c, input logic [63:0] op, input logic exp_err);
    bus_t q[$];
    bus_t w[$];
    bus_t r[$];
    logic [79:0] ew [7];
    int np, nh, nl, hc, lc, prev;
    if (c == 0) q = bq0; else q = bq1;
    foreach (q[i]) if (q[i].wr) w.push_back(q[i]); else r.push_back(q[i]);
    np = 0; nh = 0; nl = 0; hc = -1; lc = -1; prev = -1;
    foreach (r[i]) begin
      if (r[i].addr == 16'h0010) begin
        if (prev >= 0) chk("poll_gap_ge5", 128'((r[i].cyc - prev) >= 5), 128'd1);
        prev = r[i].cyc; np++;
      end else if (r[i].addr == 16'h0028) begin
        nh++; hc = r[i].cyc;
      end else if (r[i].addr == 16'h0030) begin
        nl++; lc = r[i].cyc;
      end else begin
        chk("read_addr", 128'(r[i].addr), 128'h10);
      end
    end
    ew[0] = {16'h0008, 64'd1};
    ew[1] = {16'h0008, 64'd0};
    ew[2] = {16'h0020, op};
    ew[3] = {16'h0018, (c == 0) ? 64'd1 : 64'd0};
    ew[4] = {16'h0000, 64'd1};
    ew[5] = {16'h0008, 64'd1};
    ew[6] = {16'h0008, 64'd0};
    chk("write_count", 128'(w.size()), 128'd7);
    if (w.size() == 7) begin
      for (int i = 0; i < 7; i++)
        chk($sformatf("write%0d", i), 128'({w[i].addr, w[i].dout}), 128'(ew[i]));
      chk("clr1_latency", 128'(w[0].cyc), 128'(last_tc + 1));
      chk("wstart_latency", 128'(w[4].cyc), 128'(last_tc + 5));
      chk("fclr_back_to_back", 128'(w[6].cyc), 128'(w[5].cyc + 1));
      if (exp_err) chk("timeout_res_valid", 128'(last_rv), 128'(w[4].cyc + 1 + 53));
      else         chk("fclr_after_rdl", 128'(w[5].cyc), 128'(lc + 1));
    end
    if (exp_err) begin
      chk("no_rdh_on_timeout", 128'(nh), 128'd0);
      chk("no_rdl_on_timeout", 128'(nl), 128'd0);
    end else begin
      chk("rdh_count", 128'(nh), 128'd1);
      chk("rdl_count", 128'(nl), 128'd1);
      chk("rdl_after_rdh", 128'(lc), 128'(hc + 1));
    end
    if (c == 0) begin
      chk("no_polls_intr_mode", 128'(np), 128'd0);
      if (!exp_err) begin
        chk("intr_seen", 128'(intr_w >= 0), 128'd1);
        chk("rdh_after_intr", 128'(hc), 128'(intr_w + 1));
        chk("rdl_after_intr", 128'(lc), 128'(intr_w + 2));
        chk("res_valid_after_intr", 128'(last_rv), 128'(intr_w + 5));
      end
    end else begin
      chk("polls_present", 128'(np >= 1), 128'd1);
    end
    chk("intr_cleared", 128'(m_intr[c]), 128'd0);
  endtask

  initial begin
    vec_t vecs [6];
    logic [127:0] d;
    logic e;
    int c, hold;
    logic [63:0] op;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cmd_valid[i] = 1'b0; res_ready[i] = 1'b0;
      cmd_operand[i] = '0; c_lat[i] = 3; c_never[i] = 1'b0;
    end
    vecs[0] = '{inst: 0, op: 64'd5,  exp_data: 128'd120, hold: 0};
    vecs[1] = '{inst: 1, op: 64'd0,  exp_data: 128'd1, hold: 0};
    vecs[2] = '{inst: 0, op: 64'd21, exp_data: {64'd2, 64'd14197454024290336768}, hold: 2};
    vecs[3] = '{inst: 1, op: 64'd21, exp_data: {64'd2, 64'd14197454024290336768}, hold: 0};
    vecs[4] = '{inst: 1, op: 64'd10, exp_data: 128'd3628800, hold: 10};
    vecs[5] = '{inst: 0, op: 64'd20, exp_data: 128'd2432902008176640000, hold: 10};

    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmd_ready", 128'(cmd_ready[i]), 128'd1);
      chk("rst_busy", 128'(busy[i]), 128'd0);
      chk("rst_res_valid", 128'(res_valid[i]), 128'd0);
      chk("rst_res_err", 128'(res_err[i]), 128'd0);
      chk("rst_res_data", res_data[i], 128'd0);
      rst[i] = 1'b0;
    end
    tick();

    foreach (vecs[i]) begin
      run_cmd(vecs[i].inst, vecs[i].op, vecs[i].hold, d, e);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 128'(e), 128'd0);
      check_seq(vecs[i].inst, vecs[i].op, 1'b0);
    end

    for (int k = 0; k < 12; k++) begin
      c        = int'($urandom_range(1, 0));
      op       = 64'($urandom_range(30, 0));
      hold     = int'($urandom_range(3, 0));
      c_lat[c] = int'($urandom_range(20, 0));
      run_cmd(c, op, hold, d, e);
      chk($sformatf("rand%0d_data", k), d, fact(op));
      chk($sformatf("rand%0d_err", k), 128'(e), 128'd0);
      check_seq(c, op, 1'b0);
    end

    c_never[0] = 1'b1;
    run_cmd(0, 64'd7, 3, d, e);
    chk("timeout_err", 128'(e), 128'd1);
    chk("timeout_data", d, 128'd0);
    check_seq(0, 64'd7, 1'b1);
    c_never[0] = 1'b0;

    c_lat[0] = 5;
    run_cmd(0, 64'd6, 0, d, e);
    chk("after_timeout_data", d, 128'd720);
    chk("after_timeout_err", 128'(e), 128'd0);
    check_seq(0, 64'd6, 1'b0);

    c_never[0]     = 1'b1;
    cmd_operand[0] = 64'd9;
    cmd_valid[0]   = 1'b1;
    tick();
    cmd_valid[0]   = 1'b0;
    repeat (10) tick();
    chk("busy_in_wait", 128'(busy[0]), 128'd1);
    #2;
    rst[0] = 1'b1;
    #1;
    chk("midrst_cmd_ready", 128'(cmd_ready[0]), 128'd1);
    chk("midrst_busy", 128'(busy[0]), 128'd0);
    chk("midrst_res_valid", 128'(res_valid[0]), 128'd0);
    chk("midrst_res_err", 128'(res_err[0]), 128'd0);
    chk("midrst_res_data", res_data[0], 128'd0);
    chk("midrst_bus", 128'({m_sel[0], m_wr[0], m_addr[0], m_dout[0]}), 128'd0);
    bq0.delete();
    tick();
    tick();
    chk("no_bus_during_reset", 128'(bq0.size()), 128'd0);
    rst[0]     = 1'b0;
    c_never[0] = 1'b0;
    tick();
    run_cmd(0, 64'd3, 0, d, e);
    chk("post_reset_data", d, 128'd6);
    chk("post_reset_err", 128'(e), 128'd0);
    check_seq(0, 64'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
